// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory stage.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    ADDR_RESULT = 2'b00,
    ADDR_STACK  = 2'b01,
    ADDR_VECTOR = 2'b10,
    ADDR_ALT    = 2'b11
  } addr_sel_t;

  typedef enum logic [1:0] {
    WSRC_REG   = 2'b00,
    WSRC_PC    = 2'b01,
    WSRC_FLAGS = 2'b10,
    WSRC_ALT   = 2'b11
  } wsrc_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SP_ADDR_SP = 2'b00,
    SP_ADDR_P1 = 2'b01,
    SP_ADDR_P2 = 2'b10,
    SP_ADDR_M1 = 2'b11
  } sp_addr_t;

  localparam logic [31:0] SP_RESET = 32'h000F_FFFF;
  localparam logic [1:0]  WB_FLAGS = 2'b11;

  typedef struct packed {
    logic [15:0] result;
    logic [15:0] read_data1;
    logic [31:0] pc;
    logic [15:0] ldm;
    logic [2:0]  flags;
    logic        mem_read;
    logic        mem_write;
    logic        mem_push;
    logic        mem_pop;
    logic        reg_write;
    logic        pc_enable;
    logic [1:0]  wb_sel;
    addr_sel_t   addr_sel;
    wsrc_t       wsrc;
  } ex_mem_op_t;

  // Two-word ops: PC push (pop wins over push) or PC pop.
  function automatic logic is_two_word(input ex_mem_op_t op);
    return (op.mem_push && !op.mem_pop && op.wsrc == WSRC_PC) ||
           (op.mem_pop && op.pc_enable);
  endfunction

endpackage

// File: rtl/stack_pointer_unit.sv
// 32-bit stack pointer with +/-1, +/-2 updates and SP-relative address output.
module stack_pointer_unit
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        inc1,
  input  logic        inc2,
  input  logic        dec1,
  input  logic        dec2,
  input  sp_addr_t    addr_sel,
  output logic [31:0] addr
);

  logic [31:0] sp_q;

  // SP update; arithmetic wraps modulo 2^32.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sp_q <= SP_RESET;
    end else if (inc2) begin
      sp_q <= sp_q + 32'd2;
    end else if (inc1) begin
      sp_q <= sp_q + 32'd1;
    end else if (dec2) begin
      sp_q <= sp_q - 32'd2;
    end else if (dec1) begin
      sp_q <= sp_q - 32'd1;
    end
  end

  // Stack-relative address for the current access.
  always_comb begin
    addr = sp_q;
    case (addr_sel)
      SP_ADDR_SP: addr = sp_q;
      SP_ADDR_P1: addr = sp_q + 32'd1;
      SP_ADDR_P2: addr = sp_q + 32'd2;
      SP_ADDR_M1: addr = sp_q - 32'd1;
      default:    addr = sp_q;
    endcase
  end

endmodule

// File: rtl/var_reg.sv
// Generic enabled register with synchronous active-low reset to zero.
module var_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load d when enabled, clear on reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: data-memory access, stack ops, MEM/WB register.
module memory_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] result_in,
  input  logic [15:0] read_data1_in,
  input  logic [31:0] PC_in,
  input  logic [15:0] LDM_value_in,
  input  logic [2:0]  flag_register_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_push,
  input  logic        mem_pop,
  input  logic        reg_write,
  input  logic        pc_enable,
  input  logic [1:0]  wb_sel,
  input  logic [1:0]  memory_address_select,
  input  logic [1:0]  memory_write_src_select,
  output logic [31:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  output logic        dmem_we,
  output logic        dmem_re,
  input  logic [15:0] dmem_rdata,
  output logic [15:0] mem_data_out,
  output logic [15:0] result_out,
  output logic [15:0] LDM_value_out,
  output logic        reg_write_out,
  output logic [1:0]  wb_sel_out,
  output logic        pc_enable_out,
  output logic [31:0] popped_PC_out,
  output logic        popped_PC_valid,
  output logic [2:0]  conditions_from_memory_pop,
  output logic        stall_out,
  output logic [15:0] reg_data_from_mem
);

  state_t     state_q;
  ex_mem_op_t in_op;
  ex_mem_op_t held_op;
  ex_mem_op_t cur_op;
  logic [15:0] pop_low_q;

  logic       first;
  logic       two_word;
  logic       do_pop;
  logic       do_push;
  logic       do_read;
  logic       do_write;
  logic       stall;
  logic       sp_inc1;
  logic       sp_inc2;
  logic       sp_dec1;
  logic       sp_dec2;
  sp_addr_t   sp_addr_sel;
  logic [31:0] stack_addr;

  // Bundle the live EX/MEM inputs into one op record.
  always_comb begin
    in_op            = '0;
    in_op.result     = result_in;
    in_op.read_data1 = read_data1_in;
    in_op.pc         = PC_in;
    in_op.ldm        = LDM_value_in;
    in_op.flags      = flag_register_in;
    in_op.mem_read   = mem_read;
    in_op.mem_write  = mem_write;
    in_op.mem_push   = mem_push;
    in_op.mem_pop    = mem_pop;
    in_op.reg_write  = reg_write;
    in_op.pc_enable  = pc_enable;
    in_op.wb_sel     = wb_sel;
    in_op.addr_sel   = addr_sel_t'(memory_address_select);
    in_op.wsrc       = wsrc_t'(memory_write_src_select);
  end

  // Second cycle of a two-word op runs from the captured op, not the inputs.
  always_comb begin
    first    = (state_q == ST_IDLE);
    cur_op   = first ? in_op : held_op;
    two_word = is_two_word(cur_op);
    do_pop   = cur_op.mem_pop;
    do_push  = cur_op.mem_push & ~cur_op.mem_pop;
    do_read  = cur_op.mem_read;
    do_write = cur_op.mem_write & ~cur_op.mem_read;
    stall    = reset & first & two_word;
  end

  // SP control and stack address choice for this cycle.
  always_comb begin
    sp_inc1     = first & do_pop & ~two_word;
    sp_dec1     = first & do_push & ~two_word;
    sp_inc2     = ~first & do_pop;
    sp_dec2     = ~first & do_push;
    sp_addr_sel = SP_ADDR_SP;
    if (first) begin
      sp_addr_sel = do_pop ? SP_ADDR_P1 : SP_ADDR_SP;
    end else begin
      sp_addr_sel = do_pop ? SP_ADDR_P2 : SP_ADDR_M1;
    end
  end

  stack_pointer_unit u_sp (
    .clk      (clk),
    .reset    (reset),
    .inc1     (sp_inc1),
    .inc2     (sp_inc2),
    .dec1     (sp_dec1),
    .dec2     (sp_dec2),
    .addr_sel (sp_addr_sel),
    .addr     (stack_addr)
  );

  // Data-memory port drive.
  always_comb begin
    dmem_addr = {16'b0, cur_op.result};
    case (cur_op.addr_sel)
      ADDR_STACK:  dmem_addr = stack_addr;
      ADDR_VECTOR: dmem_addr = 32'h0;
      default:     dmem_addr = {16'b0, cur_op.result};
    endcase
    dmem_wdata = cur_op.read_data1;
    case (cur_op.wsrc)
      WSRC_PC:    dmem_wdata = first ? cur_op.pc[31:16] : cur_op.pc[15:0];
      WSRC_FLAGS: dmem_wdata = {13'b0, cur_op.flags};
      default:    dmem_wdata = cur_op.read_data1;
    endcase
    dmem_we = reset & (do_write | do_push);
    dmem_re = reset & (do_read | do_pop);
  end

  // Two-state sequencer: capture the op and the popped low word on entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      held_op   <= '0;
      pop_low_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (two_word) begin
            state_q <= ST_SECOND;
            held_op <= in_op;
            if (do_pop) begin
              pop_low_q <= dmem_rdata;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign stall_out         = stall;
  assign reg_data_from_mem = result_in;

  var_reg #(.WIDTH(16)) u_mem_data (
    .clk (clk), .reset (reset), .en (dmem_re),
    .d (dmem_rdata), .q (mem_data_out)
  );

  var_reg #(.WIDTH(16)) u_result (
    .clk (clk), .reset (reset), .en (1'b1),
    .d (cur_op.result), .q (result_out)
  );

  var_reg #(.WIDTH(16)) u_ldm (
    .clk (clk), .reset (reset), .en (1'b1),
    .d (cur_op.ldm), .q (LDM_value_out)
  );

  var_reg #(.WIDTH(5)) u_ctrl (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .d     ({cur_op.wb_sel, cur_op.reg_write & ~stall,
             cur_op.pc_enable & ~stall, ~first & do_pop}),
    .q     ({wb_sel_out, reg_write_out, pc_enable_out, popped_PC_valid})
  );

  var_reg #(.WIDTH(32)) u_popped_pc (
    .clk (clk), .reset (reset), .en (~first & do_pop),
    .d ({dmem_rdata, pop_low_q}), .q (popped_PC_out)
  );

  var_reg #(.WIDTH(3)) u_cond (
    .clk (clk), .reset (reset), .en (do_pop & (cur_op.wb_sel == WB_FLAGS)),
    .d (dmem_rdata[2:0]), .q (conditions_from_memory_pop)
  );

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage.
module tb_memory_stage;
  import mem_stage_pkg::*;

  logic        clk;
  logic        reset;
  logic [15:0] result_in;
  logic [15:0] read_data1_in;
  logic [31:0] PC_in;
  logic [15:0] LDM_value_in;
  logic [2:0]  flag_register_in;
  logic        mem_read, mem_write, mem_push, mem_pop, reg_write, pc_enable;
  logic [1:0]  wb_sel, memory_address_select, memory_write_src_select;
  logic [31:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_we, dmem_re;
  logic [15:0] dmem_rdata;
  logic [15:0] mem_data_out, result_out, LDM_value_out;
  logic        reg_write_out, pc_enable_out;
  logic [1:0]  wb_sel_out;
  logic [31:0] popped_PC_out;
  logic        popped_PC_valid;
  logic [2:0]  conditions_from_memory_pop;
  logic        stall_out;
  logic [15:0] reg_data_from_mem;

  int unsigned passes = 0;
  int unsigned total  = 0;

  memory_stage dut (
    .clk(clk), .reset(reset), .result_in(result_in), .read_data1_in(read_data1_in),
    .PC_in(PC_in), .LDM_value_in(LDM_value_in), .flag_register_in(flag_register_in),
    .mem_read(mem_read), .mem_write(mem_write), .mem_push(mem_push), .mem_pop(mem_pop),
    .reg_write(reg_write), .pc_enable(pc_enable), .wb_sel(wb_sel),
    .memory_address_select(memory_address_select),
    .memory_write_src_select(memory_write_src_select),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_re(dmem_re),
    .dmem_rdata(dmem_rdata), .mem_data_out(mem_data_out), .result_out(result_out),
    .LDM_value_out(LDM_value_out), .reg_write_out(reg_write_out), .wb_sel_out(wb_sel_out),
    .pc_enable_out(pc_enable_out), .popped_PC_out(popped_PC_out),
    .popped_PC_valid(popped_PC_valid),
    .conditions_from_memory_pop(conditions_from_memory_pop),
    .stall_out(stall_out), .reg_data_from_mem(reg_data_from_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle();
    result_in = '0; read_data1_in = '0; PC_in = '0; LDM_value_in = '0;
    flag_register_in = '0; mem_read = 0; mem_write = 0; mem_push = 0; mem_pop = 0;
    reg_write = 0; pc_enable = 0; wb_sel = '0; memory_address_select = '0;
    memory_write_src_select = '0; dmem_rdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 0;
    idle();
    mem_push = 1; mem_read = 1; memory_address_select = 2'b01;
    memory_write_src_select = 2'b01;
    #1;
    chk("rst_we", {31'b0, dmem_we}, 32'd0);
    chk("rst_re", {31'b0, dmem_re}, 32'd0);
    chk("rst_stall", {31'b0, stall_out}, 32'd0);
    tick(); tick();
    chk("rst_sp", dut.u_sp.sp_q, 32'h000F_FFFF);
    chk("rst_state", {31'b0, dut.state_q}, {31'b0, ST_IDLE});
    chk("rst_result_out", {16'b0, result_out}, 32'd0);
    chk("rst_popped_pc", popped_PC_out, 32'd0);

    // single push
    reset = 1;
    idle();
    mem_push = 1; memory_address_select = 2'b01; read_data1_in = 16'h1234;
    result_in = 16'h0BEE; LDM_value_in = 16'h5A5A;
    #1;
    chk("fwd", {16'b0, reg_data_from_mem}, 32'h0000_0BEE);
    chk("push_addr", dmem_addr, 32'h000F_FFFF);
    chk("push_wdata", {16'b0, dmem_wdata}, 32'h0000_1234);
    chk("push_we", {31'b0, dmem_we}, 32'd1);
    chk("push_stall", {31'b0, stall_out}, 32'd0);
    tick();
    chk("push_sp", dut.u_sp.sp_q, 32'h000F_FFFE);
    chk("result_out", {16'b0, result_out}, 32'h0000_0BEE);
    chk("ldm_out", {16'b0, LDM_value_out}, 32'h0000_5A5A);

    // single pop
    idle();
    mem_pop = 1; memory_address_select = 2'b01; dmem_rdata = 16'h1234;
    reg_write = 1; wb_sel = 2'b01;
    #1;
    chk("pop_addr", dmem_addr, 32'h000F_FFFF);
    chk("pop_re", {31'b0, dmem_re}, 32'd1);
    chk("pop_we", {31'b0, dmem_we}, 32'd0);
    tick();
    chk("pop_data", {16'b0, mem_data_out}, 32'h0000_1234);
    chk("pop_regwr", {31'b0, reg_write_out}, 32'd1);
    chk("pop_wbsel", {30'b0, wb_sel_out}, 32'd1);
    chk("pop_sp", dut.u_sp.sp_q, 32'h000F_FFFF);

    // two-word PC push; inputs scrambled during the second cycle
    idle();
    mem_push = 1; memory_address_select = 2'b01; memory_write_src_select = 2'b01;
    PC_in = 32'h0001_0203; reg_write = 1;
    #1;
    chk("pcpush1_addr", dmem_addr, 32'h000F_FFFF);
    chk("pcpush1_wdata", {16'b0, dmem_wdata}, 32'h0000_0001);
    chk("pcpush1_stall", {31'b0, stall_out}, 32'd1);
    tick();
    chk("pcpush1_bubble", {31'b0, reg_write_out}, 32'd0);
    chk("pcpush1_sp", dut.u_sp.sp_q, 32'h000F_FFFF);
    idle();
    read_data1_in = 16'hDEAD; PC_in = 32'hFFFF_FFFF; memory_address_select = 2'b00;
    #1;
    chk("pcpush2_addr", dmem_addr, 32'h000F_FFFE);
    chk("pcpush2_wdata", {16'b0, dmem_wdata}, 32'h0000_0203);
    chk("pcpush2_we", {31'b0, dmem_we}, 32'd1);
    chk("pcpush2_stall", {31'b0, stall_out}, 32'd0);
    tick();
    chk("pcpush2_sp", dut.u_sp.sp_q, 32'h000F_FFFD);
    chk("pcpush2_regwr", {31'b0, reg_write_out}, 32'd1);

    // two-word PC pop
    idle();
    mem_pop = 1; pc_enable = 1; memory_address_select = 2'b01; dmem_rdata = 16'h0203;
    #1;
    chk("pcpop1_addr", dmem_addr, 32'h000F_FFFE);
    chk("pcpop1_stall", {31'b0, stall_out}, 32'd1);
    tick();
    chk("pcpop1_pcen", {31'b0, pc_enable_out}, 32'd0);
    chk("pcpop1_valid", {31'b0, popped_PC_valid}, 32'd0);
    idle();
    dmem_rdata = 16'h0001;
    #1;
    chk("pcpop2_addr", dmem_addr, 32'h000F_FFFF);
    chk("pcpop2_stall", {31'b0, stall_out}, 32'd0);
    tick();
    chk("pcpop_pc", popped_PC_out, 32'h0001_0203);
    chk("pcpop_valid", {31'b0, popped_PC_valid}, 32'd1);
    chk("pcpop_pcen", {31'b0, pc_enable_out}, 32'd1);
    chk("pcpop_sp", dut.u_sp.sp_q, 32'h000F_FFFF);
    idle();
    tick();
    chk("pcpop_valid_drop", {31'b0, popped_PC_valid}, 32'd0);

    // flags pop, then hold
    idle();
    mem_pop = 1; wb_sel = 2'b11; memory_address_select = 2'b01; dmem_rdata = 16'h0005;
    #1;
    chk("fpop_addr", dmem_addr, 32'h0010_0000);
    tick();
    chk("fpop_cond", {29'b0, conditions_from_memory_pop}, 32'd5);
    chk("fpop_sp", dut.u_sp.sp_q, 32'h0010_0000);
    idle();
    dmem_rdata = 16'h0007;
    tick();
    chk("cond_hold", {29'b0, conditions_from_memory_pop}, 32'd5);
    chk("mdata_hold", {16'b0, mem_data_out}, 32'h0000_0005);

    // flags push
    idle();
    mem_push = 1; memory_address_select = 2'b01; memory_write_src_select = 2'b10;
    flag_register_in = 3'b110;
    #1;
    chk("fpush_addr", dmem_addr, 32'h0010_0000);
    chk("fpush_wdata", {16'b0, dmem_wdata}, 32'h0000_0006);
    tick();
    chk("fpush_sp", dut.u_sp.sp_q, 32'h000F_FFFF);

    // push then push+pop together
    idle();
    mem_push = 1; memory_address_select = 2'b01; read_data1_in = 16'hAAAA;
    tick();
    chk("push2_sp", dut.u_sp.sp_q, 32'h000F_FFFE);
    idle();
    mem_push = 1; mem_pop = 1; memory_address_select = 2'b01; dmem_rdata = 16'hAAAA;
    #1;
    chk("pp_we", {31'b0, dmem_we}, 32'd0);
    chk("pp_re", {31'b0, dmem_re}, 32'd1);
    chk("pp_addr", dmem_addr, 32'h000F_FFFF);
    tick();
    chk("pp_sp", dut.u_sp.sp_q, 32'h000F_FFFF);
    chk("pp_data", {16'b0, mem_data_out}, 32'h0000_AAAA);

    // read+write together and address-select variants
    idle();
    mem_read = 1; mem_write = 1; result_in = 16'h0042; dmem_rdata = 16'h1111;
    #1;
    chk("rw_we", {31'b0, dmem_we}, 32'd0);
    chk("rw_re", {31'b0, dmem_re}, 32'd1);
    chk("rw_addr", dmem_addr, 32'h0000_0042);
    memory_address_select = 2'b10;
    #1;
    chk("vec_addr", dmem_addr, 32'h0000_0000);
    memory_address_select = 2'b11;
    #1;
    chk("sel11_addr", dmem_addr, 32'h0000_0042);
    tick();
    chk("rw_data", {16'b0, mem_data_out}, 32'h0000_1111);
    chk("rw_sp", dut.u_sp.sp_q, 32'h000F_FFFF);

    // reset during second cycle of a PC push aborts it
    idle();
    mem_push = 1; memory_address_select = 2'b01; memory_write_src_select = 2'b01;
    PC_in = 32'h1234_5678;
    #1;
    chk("abort1_wdata", {16'b0, dmem_wdata}, 32'h0000_1234);
    chk("abort1_stall", {31'b0, stall_out}, 32'd1);
    tick();
    chk("abort_in_second", {31'b0, dut.state_q}, {31'b0, ST_SECOND});
    reset = 0;
    #1;
    chk("abort_we", {31'b0, dmem_we}, 32'd0);
    chk("abort_stall", {31'b0, stall_out}, 32'd0);
    tick();
    chk("abort_state", {31'b0, dut.state_q}, {31'b0, ST_IDLE});
    chk("abort_sp", dut.u_sp.sp_q, 32'h000F_FFFF);
    reset = 1;
    idle();
    #1;
    chk("after_abort_stall", {31'b0, stall_out}, 32'd0);
    chk("after_abort_we", {31'b0, dmem_we}, 32'd0);
    tick();
    chk("after_abort_sp", dut.u_sp.sp_q, 32'h000F_FFFF);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
